// File: rtl/score_display_multi.sv
// score_display_multi: draws an N-digit decimal score as seven-segment glyphs
// on the VGA pixel stream.
//
// A binary score is converted to BCD by a sequential shift-add-3 engine. The
// converted digits land in a shadow buffer and are copied to the displayed
// (active) buffer only at frame start (x_loc == 0, y_loc == 0), so a frame
// never shows a mix of old and new digits.
//
// Ports:
//   clk_d     in   pixel clock
//   rst_n     in   asynchronous active-low reset
//   x_loc     in   current pixel column
//   y_loc     in   current pixel row
//   video_on  in   active display area
//   state     in   game FSM state; score drawn only when state == SHOW_STATE
//   score     in   binary score
//   red       out  red channel   (registered, 2-cycle latency from x/y)
//   green     out  green channel (registered, 2-cycle latency from x/y)
//   blue      out  blue channel  (registered, 2-cycle latency from x/y)
//   busy      out  BCD conversion in progress
module score_display_multi #(
    parameter int unsigned NUM_DIGITS = 3,
    parameter int unsigned SCORE_W    = 10,
    parameter int unsigned X_POS      = 100,
    parameter int unsigned Y_POS      = 100,
    parameter int unsigned DIGIT_W    = 40,
    parameter int unsigned DIGIT_H    = 60,
    parameter int unsigned STROKE     = 10,
    parameter int unsigned GAP        = 10,
    parameter logic [11:0] FG         = 12'hFFF,
    parameter logic [11:0] BG         = 12'h000,
    parameter logic [1:0]  SHOW_STATE = 2'b10,
    parameter bit          BLANK_LZ   = 1'b1
) (
    input  logic               clk_d,
    input  logic               rst_n,
    input  logic [9:0]         x_loc,
    input  logic [9:0]         y_loc,
    input  logic               video_on,
    input  logic [1:0]         state,
    input  logic [SCORE_W-1:0] score,
    output logic [3:0]         red,
    output logic [3:0]         green,
    output logic [3:0]         blue,
    output logic               busy
);

    // The BCD engine is sized for the full input range so that values above
    // the displayable maximum still convert cleanly before saturation.
    localparam int unsigned BCD_FULL = (SCORE_W + 2) / 3;
    localparam int unsigned BCD_N    = (BCD_FULL > NUM_DIGITS) ? BCD_FULL : NUM_DIGITS;
    localparam int unsigned BCD_W    = 4 * BCD_N;
    localparam int unsigned DIG_W    = 4 * NUM_DIGITS;
    localparam int unsigned CNT_W    = $clog2(SCORE_W + 1);
    localparam int unsigned PITCH    = DIGIT_W + GAP;
    localparam int unsigned BOX_W    = NUM_DIGITS * DIGIT_W + (NUM_DIGITS - 1) * GAP;

    function automatic int unsigned pow10(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int unsigned k = 0; k < n; k++) r = r * 10;
        return r;
    endfunction

    localparam int unsigned MAX_VAL = pow10(NUM_DIGITS) - 1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StConv = 2'd1,
        StDone = 2'd2
    } conv_st_e;

    // ------------------------------------------------------------------
    // Converter and digit buffers
    // ------------------------------------------------------------------
    conv_st_e           conv_st_q, conv_st_d;
    logic [SCORE_W-1:0] last_score_q, last_score_d;
    logic [SCORE_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [BCD_W-1:0]   bcd_adj;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    // Nibble k holds the 10^k digit.
    logic [DIG_W-1:0]   shadow_q, shadow_d;
    logic [DIG_W-1:0]   active_q, active_d;

    always_comb begin
        conv_st_d    = conv_st_q;
        last_score_d = last_score_q;
        bin_d        = bin_q;
        bcd_d        = bcd_q;
        cnt_d        = cnt_q;
        busy_d       = busy_q;
        shadow_d     = shadow_q;
        active_d     = active_q;

        for (int unsigned k = 0; k < BCD_N; k++) begin
            bcd_adj[4*k +: 4] = (bcd_q[4*k +: 4] >= 4'd5) ? bcd_q[4*k +: 4] + 4'd3
                                                           : bcd_q[4*k +: 4];
        end

        unique case (conv_st_q)
            StIdle: begin
                if (score != last_score_q) begin
                    last_score_d = score;
                    bin_d        = score;
                    bcd_d        = '0;
                    cnt_d        = '0;
                    busy_d       = 1'b1;
                    conv_st_d    = StConv;
                end
            end
            StConv: begin
                {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
                cnt_d          = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(SCORE_W - 1)) conv_st_d = StDone;
            end
            StDone: begin
                // last_score_q only moves in StIdle, so it still holds the
                // value that was just converted.
                if (32'(last_score_q) > MAX_VAL) begin
                    shadow_d = {NUM_DIGITS{4'd9}};
                end else begin
                    shadow_d = bcd_q[DIG_W-1:0];
                end
                busy_d    = 1'b0;
                conv_st_d = StIdle;
            end
            default: conv_st_d = StIdle;
        endcase

        // Reads shadow_q, so a shadow write in this same cycle shows next frame.
        if (x_loc == 10'd0 && y_loc == 10'd0) active_d = shadow_q;
    end

    // ------------------------------------------------------------------
    // Pixel stage 1: box/cell decode and local coordinates
    // ------------------------------------------------------------------
    logic        vid_q, vid_d;
    logic        show_q, show_d;
    logic        inbox_q, inbox_d;
    logic [2:0]  idx_q, idx_d;
    logic [9:0]  lx_q, lx_d;
    logic [9:0]  ly_q, ly_d;
    logic        incell_q, incell_d;
    logic [15:0] x_w, y_w, dx, lx_w;

    always_comb begin
        x_w      = {6'd0, x_loc};
        y_w      = {6'd0, y_loc};
        vid_d    = video_on;
        show_d   = (state == SHOW_STATE);
        inbox_d  = (x_w >= 16'(X_POS)) && (x_w < 16'(X_POS + BOX_W)) &&
                   (y_w >= 16'(Y_POS)) && (y_w < 16'(Y_POS + DIGIT_H));
        dx       = x_w - 16'(X_POS);
        idx_d    = '0;
        lx_w     = dx;
        // Last cell start not beyond dx wins; only meaningful inside the box.
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (dx >= 16'(i * PITCH)) begin
                idx_d = 3'(i);
                lx_w  = dx - 16'(i * PITCH);
            end
        end
        lx_d     = lx_w[9:0];
        ly_d     = y_loc - 10'(Y_POS);
        incell_d = (lx_w < 16'(DIGIT_W));
    end

    // ------------------------------------------------------------------
    // Pixel stage 2: glyph lookup, segment hit, colour
    // ------------------------------------------------------------------
    logic [3:0]            digit;
    logic                  blank;
    logic [NUM_DIGITS-1:0] blank_vec;
    logic                  seen_nz;
    logic [6:0]            segs;    // {a,b,c,d,e,f,g}
    logic                  in_a, in_d, in_g, top, left, right, hit;
    logic [11:0]           rgb_q, rgb_d;

    always_comb begin
        // Leading-zero mask over the displayed digits, MS digit first.
        seen_nz = 1'b0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (active_q[4*(NUM_DIGITS-1-i) +: 4] != 4'd0) seen_nz = 1'b1;
            blank_vec[i] = BLANK_LZ && !seen_nz && (i != NUM_DIGITS - 1);
        end

        digit = 4'd0;
        blank = 1'b0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == 3'(i)) begin
                digit = active_q[4*(NUM_DIGITS-1-i) +: 4];
                blank = blank_vec[i];
            end
        end

        unique case (digit)
            4'd0:    segs = 7'b1111110;
            4'd1:    segs = 7'b0110000;
            4'd2:    segs = 7'b1101101;
            4'd3:    segs = 7'b1111001;
            4'd4:    segs = 7'b0110011;
            4'd5:    segs = 7'b1011011;
            4'd6:    segs = 7'b1011111;
            4'd7:    segs = 7'b1110000;
            4'd8:    segs = 7'b1111111;
            4'd9:    segs = 7'b1111011;
            default: segs = 7'b0000000;
        endcase

        in_a  = ly_q < 10'(STROKE);
        in_d  = ly_q >= 10'(DIGIT_H - STROKE);
        in_g  = (ly_q >= 10'(DIGIT_H / 2 - STROKE / 2)) &&
                (ly_q <  10'(DIGIT_H / 2 + STROKE / 2));
        top   = ly_q < 10'(DIGIT_H / 2);
        left  = lx_q < 10'(STROKE);
        right = lx_q >= 10'(DIGIT_W - STROKE);

        hit = (segs[6] && in_a) ||
              (segs[5] && right && top) ||
              (segs[4] && right && !top) ||
              (segs[3] && in_d) ||
              (segs[2] && left && !top) ||
              (segs[1] && left && top) ||
              (segs[0] && in_g);

        if (vid_q && show_q && inbox_q) begin
            rgb_d = (incell_q && !blank && hit) ? FG : BG;
        end else begin
            rgb_d = 12'h000;
        end
    end

    always_ff @(posedge clk_d or negedge rst_n) begin
        if (!rst_n) begin
            conv_st_q    <= StIdle;
            last_score_q <= '0;
            bin_q        <= '0;
            bcd_q        <= '0;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            shadow_q     <= '0;
            active_q     <= '0;
            vid_q        <= 1'b0;
            show_q       <= 1'b0;
            inbox_q      <= 1'b0;
            idx_q        <= '0;
            lx_q         <= '0;
            ly_q         <= '0;
            incell_q     <= 1'b0;
            rgb_q        <= '0;
        end else begin
            conv_st_q    <= conv_st_d;
            last_score_q <= last_score_d;
            bin_q        <= bin_d;
            bcd_q        <= bcd_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            vid_q        <= vid_d;
            show_q       <= show_d;
            inbox_q      <= inbox_d;
            idx_q        <= idx_d;
            lx_q         <= lx_d;
            ly_q         <= ly_d;
            incell_q     <= incell_d;
            rgb_q        <= rgb_d;
        end
    end

    assign red   = rgb_q[11:8];
    assign green = rgb_q[7:4];
    assign blue  = rgb_q[3:0];
    assign busy  = busy_q;

endmodule
